sat_problem_loader: RTL and testbench
=====================================

// Module: sat_problem_loader
// PURPOSE
//  Upstream feeder for one solver thread's controller. Takes a tagged host word stream (valid/ready),
//  bounds-checks each word and forwards it as a one-cycle write on the ATT, CT or UCB load channel.
//  Counts the loaded words, pulses start, raises start_run after the stream ends, and tracks run completion.
// PARAMETERS
//  NSAT                   3                         literals per clause
//  NUM_VARIABLES          2048                      variables per problem
//  MAX_CLAUSE_MEMBERSHIP  20                        max clauses per variable
//  UCB_DEPTH              2048                      unsat clause buffer entries
//  VAW                    $clog2(NUM_VARIABLES)     variable address width
//  LAW                    VAW+1                     literal address width
//  CT_WIDTH               LAW*(NSAT-1)*MAX_CLAUSE_MEMBERSHIP   clause-table word width
//  DATA_W                 CT_WIDTH                  host data width (widest payload)
// PORTS
//  clk             in   1               clock
//  rst             in   1               synchronous active-high reset
//  cmd_start_i     in   1               pulse: begin a load/run session
//  in_valid_i      in   1               host word valid
//  in_ready_o      out  1               loader accepts word (transfer = valid & ready)
//  in_tag_i        in   2               00 ATT, 01 CT, 10 UCB, 11 END
//  in_addr_i       in   LAW+1           table address
//  in_data_i       in   DATA_W          payload, LSB-aligned
//  ctl_start_o     out  1               start pulse to controller
//  ctl_start_run_o out  1               release controller from LOAD
//  ctl_load_done_i in   1               controller finished loading
//  ctl_done_i      in   1               controller reached DONE
//  att_valid_o/att_addr_o/att_data_o  out 1/LAW+1/VAW+MAX_CLAUSE_MEMBERSHIP   ATT write
//  ct_valid_o/ct_addr_o/ct_data_o     out 1/VAW/CT_WIDTH                      CT write
//  ucb_valid_o/ucb_addr_o/ucb_data_o  out 1/$clog2(UCB_DEPTH)/NSAT*LAW        UCB write
//  ucb_count_o     out  $clog2(UCB_DEPTH)+1  accepted UCB words; initial unsat count
//  err_o           out  1               sticky: at least one out-of-range word dropped
//  busy_o          out  1               state != IDLE
//  run_done_o      out  1               one-cycle pulse when the run completes
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, err_o 0, state IDLE. Reset mid-session aborts at once; no output glitches.
//  FSM: IDLE -cmd_start_i-> ARM (ctl_start_o=1 for exactly 1 cycle) -> LOAD
//       LOAD -END transfer-> DRAIN (1 cycle, last forwarded write retires) -> RELEASE
//       RELEASE: ctl_start_run_o=1, held until ctl_load_done_i=1 -> WAIT_RUN
//       WAIT_RUN: ctl_start_run_o=0, wait for ctl_done_i=1 -> run_done_o pulse, -> IDLE.
//  ARM also clears ucb_count_o and err_o. cmd_start_i outside IDLE is ignored.
//  in_ready_o=1 only in LOAD (combinational from state). The END transfer is accepted; ready drops next cycle.
//  Forwarding: a transfer in cycle N gives exactly one *_valid_o=1 in cycle N+1. Addr/data are registered
//   from the low bits of in_addr_i/in_data_i. At most one *_valid_o is high per cycle.
//   When no valid is high, all addr/data outputs are 0.
//  Range check: ATT addr < 2*NUM_VARIABLES, CT addr < NUM_VARIABLES, UCB addr < UCB_DEPTH. Checks use full in_addr_i.
//   A failing word is accepted (ready stays high) but not forwarded, and sets err_o. The session continues.
//  ucb_count_o += 1 per forwarded UCB word (duplicate addresses count too). It saturates at UCB_DEPTH.
//   It holds through WAIT_RUN and IDLE until the next ARM.
//  Back-to-back transfers at full rate are allowed. No bubble is required between tags.
//  END with zero prior words is legal: ARM, LOAD, DRAIN, RELEASE, with ucb_count_o=0.
//  If ctl_load_done_i is already 1 on entry to RELEASE, ctl_start_run_o is still 1 for 1 cycle.
//  If ctl_done_i and ctl_load_done_i rise together in RELEASE, the FSM moves to WAIT_RUN, then to IDLE next cycle.
// TESTING
//  1 reset: assert rst during LOAD with in_valid_i=1 -> next cycle all outputs 0, busy_o=0, in_ready_o=0.
//  2 stream: cmd_start; ATT@5 data 0x1234, CT@7, UCB@0..2, END sent back-to-back
//    -> ctl_start_o pulses once; ATT, CT, UCB x3 valid pulses appear on consecutive cycles with matching
//       addr/data; ucb_count_o=3; ctl_start_run_o rises 2 cycles after END.
//  3 range: ATT@4096, CT@2048, UCB@2048 (defaults) -> no valid pulses, err_o=1, ucb_count_o=0,
//    later in-range words still forwarded.
//  4 handshake: hold ctl_load_done_i=0 for 10 cycles -> start_run held 10 cycles and drops the cycle
//    after load_done; ctl_done_i=1 -> run_done_o=1 for 1 cycle, busy_o=0.
//  5 empty: cmd_start then END only -> ucb_count_o=0, start_run asserted, run completes normally.
//  6 ignore/saturate: cmd_start during WAIT_RUN has no effect; 2050 UCB words (addr wrap) -> ucb_count_o=2048.

Source files
------------

// File: rtl/sat_problem_loader_if.sv
// sat_problem_loader_if: tagged host word stream (valid/ready) feeding the problem loader
//  valid/ready : transfer handshake, a word moves when both are high
//  tag         : 00 ATT, 01 CT, 10 UCB, 11 END
//  addr/data   : table address and LSB-aligned payload
interface sat_problem_loader_if #(
  parameter int AW = 13,
  parameter int DW = 480
) ();
  logic          valid;
  logic          ready;
  logic [1:0]    tag;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  modport master (output valid, tag, addr, data, input ready);
  modport slave  (input valid, tag, addr, data, output ready);
endinterface

// File: rtl/sat_problem_loader.sv
// sat_problem_loader: bounds-checks a tagged host word stream and forwards it to the ATT/CT/UCB load channels, then sequences start/start_run/done
//  clk, rst         : clock, synchronous active-high reset
//  cmd_start_i      : begin a load/run session (honoured only when idle)
//  host             : tagged word stream, ready only while loading
//  ctl_*            : start pulse, start_run level, load_done/done from the controller
//  att_*/ct_*/ucb_* : one-cycle registered table writes
//  ucb_count_o      : forwarded UCB words (saturating), err_o sticky range error
//  busy_o, run_done_o : session active, run completion pulse
module sat_problem_loader #(
  parameter int NSAT                  = 3,
  parameter int NUM_VARIABLES         = 2048,
  parameter int MAX_CLAUSE_MEMBERSHIP = 20,
  parameter int UCB_DEPTH             = 2048,
  localparam int VAW      = $clog2(NUM_VARIABLES),
  localparam int LAW      = VAW + 1,
  localparam int CT_WIDTH = LAW * (NSAT - 1) * MAX_CLAUSE_MEMBERSHIP,
  localparam int UAW      = $clog2(UCB_DEPTH),
  localparam int ATT_DW   = VAW + MAX_CLAUSE_MEMBERSHIP,
  localparam int UCB_DW   = NSAT * LAW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_start_i,
  sat_problem_loader_if.slave  host,
  output logic                 ctl_start_o,
  output logic                 ctl_start_run_o,
  input  logic                 ctl_load_done_i,
  input  logic                 ctl_done_i,
  output logic                 att_valid_o,
  output logic [LAW:0]         att_addr_o,
  output logic [ATT_DW-1:0]    att_data_o,
  output logic                 ct_valid_o,
  output logic [VAW-1:0]       ct_addr_o,
  output logic [CT_WIDTH-1:0]  ct_data_o,
  output logic                 ucb_valid_o,
  output logic [UAW-1:0]       ucb_addr_o,
  output logic [UCB_DW-1:0]    ucb_data_o,
  output logic [UAW:0]         ucb_count_o,
  output logic                 err_o,
  output logic                 busy_o,
  output logic                 run_done_o
);
  typedef enum logic [2:0] {IDLE, ARM, LOAD, DRAIN, RELEASE, WAIT_RUN} state_t;
  state_t state, state_nxt;
  logic xfer, att_ok, ct_ok, ucb_ok, bad;
  assign host.ready      = state == LOAD;
  assign ctl_start_o     = state == ARM;
  assign ctl_start_run_o = state == RELEASE;
  assign busy_o          = state != IDLE;
  assign xfer   = host.valid && host.ready;
  assign att_ok = xfer && host.tag == 2'd0 && 32'(host.addr) < 2 * NUM_VARIABLES;
  assign ct_ok  = xfer && host.tag == 2'd1 && 32'(host.addr) < NUM_VARIABLES;
  assign ucb_ok = xfer && host.tag == 2'd2 && 32'(host.addr) < UCB_DEPTH;
  // END is never range-checked; any other tag that failed its check is a dropped word
  assign bad    = xfer && host.tag != 2'd3 && !(att_ok || ct_ok || ucb_ok);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     state_nxt = cmd_start_i ? ARM : IDLE;
      ARM:      state_nxt = LOAD;
      LOAD:     state_nxt = (xfer && host.tag == 2'd3) ? DRAIN : LOAD;
      DRAIN:    state_nxt = RELEASE;
      RELEASE:  state_nxt = ctl_load_done_i ? WAIT_RUN : RELEASE;
      WAIT_RUN: state_nxt = ctl_done_i ? IDLE : WAIT_RUN;
      default:  state_nxt = IDLE;
    endcase
  end
  // Write channels are zeroed whenever their valid is low so idle buses stay quiet
  always_ff @(posedge clk)
    if (rst) begin
      att_valid_o <= 1'b0;
      att_addr_o  <= '0;
      att_data_o  <= '0;
      ct_valid_o  <= 1'b0;
      ct_addr_o   <= '0;
      ct_data_o   <= '0;
      ucb_valid_o <= 1'b0;
      ucb_addr_o  <= '0;
      ucb_data_o  <= '0;
      ucb_count_o <= '0;
      err_o       <= 1'b0;
      run_done_o  <= 1'b0;
    end else begin
      att_valid_o <= att_ok;
      att_addr_o  <= att_ok ? host.addr : '0;
      att_data_o  <= att_ok ? host.data[ATT_DW-1:0] : '0;
      ct_valid_o  <= ct_ok;
      ct_addr_o   <= ct_ok ? host.addr[VAW-1:0] : '0;
      ct_data_o   <= ct_ok ? host.data[CT_WIDTH-1:0] : '0;
      ucb_valid_o <= ucb_ok;
      ucb_addr_o  <= ucb_ok ? host.addr[UAW-1:0] : '0;
      ucb_data_o  <= ucb_ok ? host.data[UCB_DW-1:0] : '0;
      ucb_count_o <= state == ARM ? '0 :
                     (ucb_ok && ucb_count_o != (UAW+1)'(UCB_DEPTH)) ? ucb_count_o + (UAW+1)'(1) : ucb_count_o;
      err_o       <= state == ARM ? 1'b0 : err_o | bad;
      run_done_o  <= state == WAIT_RUN && ctl_done_i;
    end
endmodule

// File: tb/tb_sat_problem_loader.sv
// tb_sat_problem_loader: directed self-checking bench for sat_problem_loader
module tb_sat_problem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_start_i = 1'b0;
  logic ctl_load_done_i = 1'b0;
  logic ctl_done_i = 1'b0;
  logic ctl_start_o, ctl_start_run_o;
  logic att_valid_o, ct_valid_o, ucb_valid_o;
  logic [12:0]  att_addr_o;
  logic [30:0]  att_data_o;
  logic [10:0]  ct_addr_o;
  logic [479:0] ct_data_o;
  logic [10:0]  ucb_addr_o;
  logic [35:0]  ucb_data_o;
  logic [11:0]  ucb_count_o;
  logic err_o, busy_o, run_done_o;
  int n_cmp = 0;
  int n_bad = 0;
  logic [479:0] ct_word;
  sat_problem_loader_if #(.AW(13), .DW(480)) hst ();
  sat_problem_loader dut (
    .clk(clk), .rst(rst), .cmd_start_i(cmd_start_i), .host(hst),
    .ctl_start_o(ctl_start_o), .ctl_start_run_o(ctl_start_run_o),
    .ctl_load_done_i(ctl_load_done_i), .ctl_done_i(ctl_done_i),
    .att_valid_o(att_valid_o), .att_addr_o(att_addr_o), .att_data_o(att_data_o),
    .ct_valid_o(ct_valid_o), .ct_addr_o(ct_addr_o), .ct_data_o(ct_data_o),
    .ucb_valid_o(ucb_valid_o), .ucb_addr_o(ucb_addr_o), .ucb_data_o(ucb_data_o),
    .ucb_count_o(ucb_count_o), .err_o(err_o), .busy_o(busy_o), .run_done_o(run_done_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] t, input logic [12:0] a, input logic [479:0] d);
    hst.valid = 1'b1;
    hst.tag   = t;
    hst.addr  = a;
    hst.data  = d;
    tick();
  endtask
  task automatic idle_in();
    hst.valid = 1'b0;
    hst.tag   = 2'd0;
    hst.addr  = '0;
    hst.data  = '0;
  endtask
  task automatic arm();
    cmd_start_i = 1'b1;
    tick();
    cmd_start_i = 1'b0;
    tick();
  endtask
  initial begin
    int hi;
    idle_in();
    ct_word = {1'b1, 463'b0, 16'hC0DE};
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy_o, 0);
    check("rst_ready", hst.ready, 0);
    check("rst_cnt", ucb_count_o, 0);
    // reset in the middle of LOAD with a word on the bus
    arm();
    check("t1_ready", hst.ready, 1);
    hst.valid = 1'b1;
    hst.tag   = 2'd0;
    hst.addr  = 13'd3;
    hst.data  = 480'h55;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_in();
    check("t1_busy", busy_o, 0);
    check("t1_ready0", hst.ready, 0);
    check("t1_outs", {ctl_start_o, ctl_start_run_o, att_valid_o, ct_valid_o, ucb_valid_o, err_o, run_done_o}, 0);
    check("t1_bus", {att_addr_o, att_data_o, ct_addr_o, ct_data_o, ucb_addr_o, ucb_data_o, ucb_count_o}, 0);
    // back-to-back stream
    cmd_start_i = 1'b1;
    tick();
    cmd_start_i = 1'b0;
    check("t2_start", ctl_start_o, 1);
    check("t2_ready_arm", hst.ready, 0);
    tick();
    check("t2_start_once", ctl_start_o, 0);
    check("t2_ready", hst.ready, 1);
    send(2'd0, 13'd5, 480'h1234);
    check("t2_att_v", {att_valid_o, ct_valid_o, ucb_valid_o}, 3'b100);
    check("t2_att_a", att_addr_o, 5);
    check("t2_att_d", att_data_o, 31'h1234);
    send(2'd1, 13'd7, ct_word);
    check("t2_ct_v", {att_valid_o, ct_valid_o, ucb_valid_o}, 3'b010);
    check("t2_ct_a", ct_addr_o, 7);
    check("t2_ct_d", ct_data_o, ct_word);
    check("t2_att_zero", {att_addr_o, att_data_o}, 0);
    for (int i = 0; i < 3; i++) begin
      send(2'd2, 13'(i), 480'(36'h100 + i));
      check("t2_ucb_v", {att_valid_o, ct_valid_o, ucb_valid_o}, 3'b001);
      check("t2_ucb_a", ucb_addr_o, i);
      check("t2_ucb_d", ucb_data_o, 36'h100 + i);
    end
    send(2'd3, 13'd0, 480'h0);
    idle_in();
    check("t2_end_v", {att_valid_o, ct_valid_o, ucb_valid_o}, 0);
    check("t2_cnt", ucb_count_o, 3);
    check("t2_ready_drain", hst.ready, 0);
    check("t2_sr_drain", ctl_start_run_o, 0);
    tick();
    check("t2_sr", ctl_start_run_o, 1);
    ctl_load_done_i = 1'b1;
    tick();
    ctl_load_done_i = 1'b0;
    check("t2_sr_drop", ctl_start_run_o, 0);
    ctl_done_i = 1'b1;
    tick();
    ctl_done_i = 1'b0;
    check("t2_rdone", run_done_o, 1);
    check("t2_idle", busy_o, 0);
    tick();
    check("t2_rdone_pulse", run_done_o, 0);
    check("t2_cnt_hold", ucb_count_o, 3);
    // range checks at the boundaries
    arm();
    check("t3_cnt_clr", ucb_count_o, 0);
    send(2'd0, 13'd4096, 480'h1);
    check("t3_att_oor", att_valid_o, 0);
    send(2'd1, 13'd2048, 480'h2);
    check("t3_ct_oor", ct_valid_o, 0);
    send(2'd2, 13'd2048, 480'h3);
    check("t3_ucb_oor", ucb_valid_o, 0);
    check("t3_err", err_o, 1);
    check("t3_cnt0", ucb_count_o, 0);
    check("t3_ready", hst.ready, 1);
    send(2'd0, 13'd4095, 480'h7FFFFFFF);
    check("t3_att_in", {att_valid_o, att_addr_o, att_data_o}, {1'b1, 13'd4095, 31'h7FFFFFFF});
    send(2'd1, 13'd2047, 480'h9);
    check("t3_ct_in", {ct_valid_o, ct_addr_o}, {1'b1, 11'd2047});
    send(2'd2, 13'd2047, 480'hA);
    check("t3_ucb_in", {ucb_valid_o, ucb_addr_o, ucb_data_o}, {1'b1, 11'd2047, 36'hA});
    check("t3_cnt1", ucb_count_o, 1);
    send(2'd3, 13'd0, 480'h0);
    idle_in();
    tick();
    // start_run held while load_done stays low
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      hi += int'(ctl_start_run_o);
      tick();
    end
    check("t4_sr_held", hi, 10);
    ctl_load_done_i = 1'b1;
    check("t4_sr_last", ctl_start_run_o, 1);
    tick();
    ctl_load_done_i = 1'b0;
    check("t4_sr_drop", {ctl_start_run_o, busy_o}, 2'b01);
    ctl_done_i = 1'b1;
    tick();
    ctl_done_i = 1'b0;
    check("t4_rdone", {run_done_o, busy_o}, 2'b10);
    check("t4_err_sticky", err_o, 1);
    tick();
    check("t4_rdone_pulse", run_done_o, 0);
    // empty session; load_done and done both already high on entry to RELEASE
    arm();
    check("t5_err_clr", err_o, 0);
    check("t5_cnt", ucb_count_o, 0);
    send(2'd3, 13'd0, 480'h0);
    idle_in();
    ctl_load_done_i = 1'b1;
    ctl_done_i = 1'b1;
    tick();
    check("t5_sr", ctl_start_run_o, 1);
    tick();
    check("t5_wait", {ctl_start_run_o, busy_o, run_done_o}, 3'b010);
    tick();
    ctl_load_done_i = 1'b0;
    ctl_done_i = 1'b0;
    check("t5_rdone", {run_done_o, busy_o}, 2'b10);
    check("t5_cnt_end", ucb_count_o, 0);
    tick();
    // saturation, then start ignored while running
    arm();
    for (int i = 0; i < 2050; i++) begin
      send(2'd2, 13'(i % 2048), 480'(i));
      if (i == 2046) check("t6_cnt2047", ucb_count_o, 2047);
    end
    check("t6_sat", ucb_count_o, 2048);
    check("t6_last_addr", ucb_addr_o, 1);
    send(2'd3, 13'd0, 480'h0);
    idle_in();
    tick();
    ctl_load_done_i = 1'b1;
    tick();
    ctl_load_done_i = 1'b0;
    cmd_start_i = 1'b1;
    tick();
    cmd_start_i = 1'b0;
    check("t6_ignore", {ctl_start_o, ctl_start_run_o, busy_o, hst.ready}, 4'b0010);
    check("t6_cnt_hold", ucb_count_o, 2048);
    ctl_done_i = 1'b1;
    tick();
    ctl_done_i = 1'b0;
    check("t6_rdone", {run_done_o, busy_o}, 2'b10);
    tick();
    check("t6_no_rearm", {ctl_start_o, busy_o}, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
